scancode_decoder: RTL
=====================

SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of ASCII FIFO entries; SHALL be a power of two, ≥2.
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port char_in, input, 8, raw PS/2 set-2 scan-code byte from keyboard_controller char_out.
REQ-005 SHALL have port char_recv, input, 1, one-cycle strobe qualifying char_in.
REQ-006 SHALL have port ascii_out, output, 8, FIFO head character, valid while ascii_valid=1.
REQ-007 SHALL have port ascii_valid, output, 1, FIFO non-empty.
REQ-008 SHALL have port ascii_rd, input, 1, pop request; honoured only when ascii_valid=1.
REQ-009 SHALL have port shift_active, output, 1, either shift key currently held.
REQ-010 SHALL have port caps_active, output, 1, caps-lock toggle state.
REQ-011 SHALL have port overflow, output, 1, sticky flag set when a character is dropped on full FIFO.

Function
REQ-012 SHALL run FSM IDLE, EXT, BREAK, EXT_BREAK; transitions only on cycles with char_recv=1.
REQ-013 IDLE: 8'hF0 -> BREAK; 8'hE0 -> EXT; any other byte is a make code, processed, stay IDLE.
REQ-014 EXT: 8'hF0 -> EXT_BREAK; any other byte discarded (extended keys produce no output) -> IDLE.
REQ-015 BREAK: 8'h12/8'h59 clear shift_active; any other byte ignored; -> IDLE. EXT_BREAK: byte discarded -> IDLE.
REQ-016 Make 8'h12/8'h59 SHALL set shift_active; make 8'h58 SHALL toggle caps_active (see Configuration); neither pushes a character.
REQ-017 Other make codes SHALL map via the package table: letters, digits 0-9, space (29->8'h20), enter (5A->8'h0D), backspace (66->8'h08), punctuation row; unmapped codes (incl. 8'hFA ack, 8'hAA BAT) produce nothing.
REQ-018 Letter case SHALL be upper when shift_active XOR caps_active; digits/punctuation take shifted symbol when shift_active only.
REQ-019 Bytes 8'h00 and 8'hFF (keyboard error) SHALL force FSM to IDLE from any state, no output.
REQ-020 Decode SHALL be combinational from char_in and state; push on the same edge that samples char_recv; ascii_valid rises the following cycle (1-cycle latency) when FIFO was empty.
REQ-021 FIFO SHALL be show-ahead; pop when ascii_rd && ascii_valid; ascii_rd while empty ignored, no pointer movement.
REQ-022 Push while full and no pop: character dropped, contents unchanged, overflow set; cleared only by reset.
REQ-023 Simultaneous push and pop while full: both occur, count unchanged, overflow unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-025 rst=0 SHALL immediately force FSM IDLE, FIFO empty, ascii_valid=0, ascii_out=8'h00, shift_active=0, caps_active=0, overflow=0, including mid-sequence (pending F0/E0 lost).
REQ-026 First char_recv after rst deassertion SHALL be decoded normally.

Configuration
REQ-027 Macro SCANCODE_CAPS_LOCK_EN defined: 8'h58 toggles caps_active per REQ-016/018.
REQ-028 Macro undefined: 8'h58 treated as unmapped, caps_active tied 0, no caps-lock flop synthesised.

Structure
REQ-029 Package scancode_pkg SHALL hold FSM state enum, constants PREFIX_BREAK=8'hF0, PREFIX_EXT=8'hE0, LSHIFT=8'h12, RSHIFT=8'h59, CAPS=8'h58, and the scan-code-to-ASCII lookup function (unshifted/shifted).
REQ-030 FIFO SHALL be sub-module ascii_fifo (parameter FIFO_DEPTH, width 8); FSM and shift/caps logic in scancode_decoder.

Verification
REQ-031 Bytes 1C, F0, 1C -> one 8'h61 ('a'), ascii_valid high 1 cycle after first strobe, then pop -> empty.
REQ-032 12, 1C, F0, 1C, F0, 12, 1C -> 8'h41, 8'h61; shift_active high between 12 and F0 12.
REQ-033 E0, 75, E0, F0, 75, then 16 -> only 8'h31 ('1'); FSM back in IDLE after each extended sequence.
REQ-034 FIFO_DEPTH=8, ten make 29 with no pops -> 8 entries of 8'h20, overflow=1; push+pop same cycle when full -> overflow unchanged.
REQ-035 With SCANCODE_CAPS_LOCK_EN: 58, F0, 58, 1C -> 8'h41; plus 12 held -> 8'h61; without macro -> 8'h61 and caps_active=0.
REQ-036 Assert rst after F0 received, release, send 1C -> 8'h61 output, no break applied.

Source files
------------

// File: rtl/scancode_pkg.sv
// -----------------------------------------------------------------------------
// scancode_pkg
// Shared definitions for the PS/2 set-2 scan-code decoder:
//   - state_e        : prefix-tracking FSM states
//   - PREFIX_*/shift/caps scan-code constants
//   - ascii_t        : lookup result (valid flag + character)
//   - scan_to_ascii(): make-code to ASCII table with shift/caps handling
// -----------------------------------------------------------------------------
package scancode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_e;

  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] LSHIFT       = 8'h12;
  localparam logic [7:0] RSHIFT       = 8'h59;
  localparam logic [7:0] CAPS         = 8'h58;
  // Keyboard error bytes; they resynchronise the FSM to IDLE.
  localparam logic [7:0] KBD_ERR_LO   = 8'h00;
  localparam logic [7:0] KBD_ERR_HI   = 8'hFF;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } ascii_t;

  // Letters select case on shift^caps; every other entry selects its shifted
  // symbol on shift alone. Codes not listed (including ack/BAT) are invalid.
  function automatic ascii_t scan_to_ascii(input logic [7:0] code,
                                           input logic       shift,
                                           input logic       caps);
    logic [7:0] un;
    logic [7:0] sh;
    logic       letter;
    ascii_t     res;
    un     = 8'h00;
    sh     = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: begin un = "a"; sh = "A"; letter = 1'b1; end
      8'h32: begin un = "b"; sh = "B"; letter = 1'b1; end
      8'h21: begin un = "c"; sh = "C"; letter = 1'b1; end
      8'h23: begin un = "d"; sh = "D"; letter = 1'b1; end
      8'h24: begin un = "e"; sh = "E"; letter = 1'b1; end
      8'h2B: begin un = "f"; sh = "F"; letter = 1'b1; end
      8'h34: begin un = "g"; sh = "G"; letter = 1'b1; end
      8'h33: begin un = "h"; sh = "H"; letter = 1'b1; end
      8'h43: begin un = "i"; sh = "I"; letter = 1'b1; end
      8'h3B: begin un = "j"; sh = "J"; letter = 1'b1; end
      8'h42: begin un = "k"; sh = "K"; letter = 1'b1; end
      8'h4B: begin un = "l"; sh = "L"; letter = 1'b1; end
      8'h3A: begin un = "m"; sh = "M"; letter = 1'b1; end
      8'h31: begin un = "n"; sh = "N"; letter = 1'b1; end
      8'h44: begin un = "o"; sh = "O"; letter = 1'b1; end
      8'h4D: begin un = "p"; sh = "P"; letter = 1'b1; end
      8'h15: begin un = "q"; sh = "Q"; letter = 1'b1; end
      8'h2D: begin un = "r"; sh = "R"; letter = 1'b1; end
      8'h1B: begin un = "s"; sh = "S"; letter = 1'b1; end
      8'h2C: begin un = "t"; sh = "T"; letter = 1'b1; end
      8'h3C: begin un = "u"; sh = "U"; letter = 1'b1; end
      8'h2A: begin un = "v"; sh = "V"; letter = 1'b1; end
      8'h1D: begin un = "w"; sh = "W"; letter = 1'b1; end
      8'h22: begin un = "x"; sh = "X"; letter = 1'b1; end
      8'h35: begin un = "y"; sh = "Y"; letter = 1'b1; end
      8'h1A: begin un = "z"; sh = "Z"; letter = 1'b1; end
      8'h45: begin un = "0"; sh = ")"; end
      8'h16: begin un = "1"; sh = "!"; end
      8'h1E: begin un = "2"; sh = "@"; end
      8'h26: begin un = "3"; sh = "#"; end
      8'h25: begin un = "4"; sh = "$"; end
      8'h2E: begin un = "5"; sh = "%"; end
      8'h36: begin un = "6"; sh = "^"; end
      8'h3D: begin un = "7"; sh = "&"; end
      8'h3E: begin un = "8"; sh = "*"; end
      8'h46: begin un = "9"; sh = "("; end
      8'h0E: begin un = 8'h60; sh = "~"; end
      8'h4E: begin un = "-"; sh = "_"; end
      8'h55: begin un = "="; sh = "+"; end
      8'h54: begin un = "["; sh = "{"; end
      8'h5B: begin un = "]"; sh = "}"; end
      8'h5D: begin un = "\\"; sh = "|"; end
      8'h4C: begin un = ";"; sh = ":"; end
      8'h52: begin un = "'"; sh = "\""; end
      8'h41: begin un = ","; sh = "<"; end
      8'h49: begin un = "."; sh = ">"; end
      8'h4A: begin un = "/"; sh = "?"; end
      8'h29: begin un = 8'h20; sh = 8'h20; end
      8'h5A: begin un = 8'h0D; sh = 8'h0D; end
      8'h66: begin un = 8'h08; sh = 8'h08; end
      default: begin un = 8'h00; sh = 8'h00; end
    endcase
    res.valid = (un != 8'h00);
    if (letter) res.ascii = (shift ^ caps) ? sh : un;
    else        res.ascii = shift ? sh : un;
    return res;
  endfunction

endpackage

// File: rtl/scancode_decoder_fifo.sv
// -----------------------------------------------------------------------------
// ascii_fifo
// Show-ahead character FIFO. FIFO_DEPTH must be a power of two >= 2 so the
// pointers wrap by natural overflow.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data   : write strobe and character
//   pop               : read strobe, ignored while empty
//   head_data         : head character, 8'h00 while empty
//   not_empty         : head_data is valid
//   overflow          : sticky, set when a push is dropped on a full FIFO
// -----------------------------------------------------------------------------
module ascii_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       not_empty,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, do_push, do_pop;

  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    do_pop     = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    do_push    = push && (!full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so
  // stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign not_empty = !empty;
  assign head_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;

endmodule

// File: rtl/scancode_decoder.sv
// -----------------------------------------------------------------------------
// scancode_decoder
// Turns PS/2 set-2 scan-code bytes into ASCII characters buffered in a FIFO.
// Tracks break (F0) and extended (E0) prefixes, shift state and, optionally,
// caps lock.
// Build option: define SCANCODE_CAPS_LOCK_EN to make 8'h58 toggle caps lock;
// otherwise 8'h58 is unmapped and caps_active is tied low.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   char_in, char_recv      : scan-code byte and its one-cycle strobe
//   ascii_out, ascii_valid  : FIFO head character and non-empty flag
//   ascii_rd                : pop request, honoured only while ascii_valid
//   shift_active            : either shift key held
//   caps_active             : caps-lock toggle state
//   overflow                : sticky dropped-character flag
// -----------------------------------------------------------------------------
module scancode_decoder
  import scancode_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_recv,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_rd,
  output logic       shift_active,
  output logic       caps_active,
  output logic       overflow
);

  state_e     state_q, state_d;
  logic       shift_q, shift_d;
  logic       push;
  logic [7:0] push_data;
  ascii_t     lk;

`ifdef SCANCODE_CAPS_LOCK_EN
  logic caps_q, caps_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) caps_q <= 1'b0;
    else      caps_q <= caps_d;
  end

  assign caps_active = caps_q;
`else
  assign caps_active = 1'b0;
`endif

  assign lk = scan_to_ascii(char_in, shift_q, caps_active);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_data = lk.ascii;
`ifdef SCANCODE_CAPS_LOCK_EN
    caps_d    = caps_q;
`endif
    if (char_recv) begin
      if (char_in == KBD_ERR_LO || char_in == KBD_ERR_HI) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (char_in == PREFIX_BREAK) begin
              state_d = ST_BREAK;
            end else if (char_in == PREFIX_EXT) begin
              state_d = ST_EXT;
            end else if (char_in == LSHIFT || char_in == RSHIFT) begin
              shift_d = 1'b1;
`ifdef SCANCODE_CAPS_LOCK_EN
            end else if (char_in == CAPS) begin
              caps_d = !caps_q;
`endif
            end else begin
              push = lk.valid;
            end
          end
          ST_EXT: begin
            // Extended keys produce no characters; only a pending break matters.
            state_d = (char_in == PREFIX_BREAK) ? ST_EXT_BREAK : ST_IDLE;
          end
          ST_BREAK: begin
            if (char_in == LSHIFT || char_in == RSHIFT) shift_d = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  assign shift_active = shift_q;

  ascii_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (ascii_rd),
    .head_data (ascii_out),
    .not_empty (ascii_valid),
    .overflow  (overflow)
  );

endmodule
